sha256_compress: RTL
====================

// Module: sha256_compress
// PURPOSE
//  SHA-256 compression engine; sits directly downstream of wGenerator and consumes its W[t] stream, one word/round.
//  Runs 64 rounds on working vars a..h, adds the result into the chaining hash H and presents a 256-bit digest.
//  Supports multi-block messages by chaining H between blocks.
// PARAMETERS
//  ROUNDS       64   rounds per block; fixed by SHA-256, exposed only for reduced-round debug builds
//  WORD_W       32   word width; fixed by SHA-256
// PORTS
//  ap_clk        in   1    single clock, all flops rising edge
//  ap_rst_n      in   1    asynchronous, active-low reset
//  blk_start     in   1    start new block; sampled only in IDLE, or in OUT together with a digest handshake
//  init_iv       in   1    with blk_start: 1 = load IV into H first, 0 = chain from current H
//  w_valid       in   1    W[t] word valid, from wGenerator
//  w_ready       out  1    engine accepts W[t]
//  w_data        in   32   W[t], t = 0..63 in order
//  digest_valid  out  1    digest available
//  digest_ready  in   1    downstream accepts digest
//  digest        out  256  H0..H7, H0 in [255:224]
//  busy          out  1    state != IDLE
//  round_idx     out  6    index t of next word to be consumed
// BEHAVIOUR
//  Reset: state IDLE; w_ready=0, digest_valid=0, busy=0, round_idx=0; H regs and a..h = SHA-256 IV; digest = IV.
//  Reset mid-operation aborts the block immediately; no partial digest is ever presented.
//  FSM IDLE -> ROUND -> FINAL -> OUT -> IDLE.
//   IDLE: blk_start=1 -> if init_iv, H<=IV and a..h<=IV; else a..h<=H. round_idx<=0; -> ROUND.
//   ROUND: w_ready=1. Each edge with w_valid&w_ready performs one round with K[round_idx], W=w_data; round_idx++.
//          w_valid=0 stalls; a..h and round_idx hold. Word 63 accepted -> FINAL; round_idx wraps to 0.
//   FINAL: H[i] <= H[i] + var[i] (mod 2^32, per word); -> OUT. w_ready=0.
//   OUT: digest_valid=1; digest is stable until handshake. digest_valid&digest_ready -> IDLE.
//        Same edge with blk_start=1: handshake completes and new block starts as in IDLE (-> ROUND); back-to-back, no bubble.
//  blk_start in ROUND/FINAL, or in OUT without digest_ready, is ignored (not queued).
//  Round: T1 = h + S1(e) + Ch(e,f,g) + K[t] + W; T2 = S0(a) + Maj(a,b,c); all adds mod 2^32, carries dropped.
//         h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2.
//  Latency: start edge 0, W every cycle on edges 1..64, FINAL edge 65, digest_valid high from cycle 66. Throughput: 1 block / 66 cycles.
//  digest is driven straight from H regs; between blocks it shows the last digest.
// CONFIGURATION
//  SHA224_EN defined: adds input mode_224 (1 bit), sampled with blk_start&init_iv; selects the SHA-224 IV;
//    while the block was started in 224 mode, digest[31:0] is forced to 0 (7-word SHA-224 digest).
//    mode_224 is ignored when init_iv=0 (the chain keeps its mode).
//  SHA224_EN undefined: no mode_224 port; SHA-256 IV only; digest carries all 8 words.
// STRUCTURE
//  sha2_pkg: K[0:63] constant table, IV256/IV224 constants, functions big_sigma0/1, ch, maj, FSM state enum.
//  Sub-module sha256_round: combinational a..h + K + W -> next a..h; instantiated once in the round datapath.
//  Top holds FSM, round counter, H regs, a..h regs and handshake logic.
// TESTING
//  1 "abc" padded block, init_iv=1, W every cycle -> digest ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad, valid cycle 66.
//  2 448-bit "abcdbcdecdefghij..." two blocks, 2nd init_iv=0 -> 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
//  3 Test 1 with w_valid toggled every cycle -> same digest; round_idx holds on stall cycles; valid at cycle 130.
//  4 digest_ready low 10 cycles, blk_start pulsed in OUT -> digest/digest_valid stable, w_ready=0, start ignored; then handshake + blk_start same edge -> back-to-back block.
//  5 ap_rst_n low at round_idx=30 -> all outputs at reset values immediately; fresh "abc" block then yields test 1 digest.
//  6 SHA224_EN, mode_224=1, "abc" -> 23097d22 3405d822 8642a477 bda255b3 2aadbce4 bda0b3f7 e36c9da7, digest[31:0]=0.

Source files
------------

// File: rtl/sha2_pkg.sv
// sha2_pkg: shared SHA-2 definitions for the compression engine.
//   - work_t     : eight 32-bit words a..h (a / H0 in the top bits)
//   - IV256/IV224: initial hash values (IV224 used only when SHA224_EN is defined)
//   - K          : 64 round constants, read through k_const()
//   - big_sigma0/1, ch, maj: round functions; add_work: word-wise mod 2^32 add
//   - state_t    : compression FSM states
package sha2_pkg;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] c;
        logic [31:0] d;
        logic [31:0] e;
        logic [31:0] f;
        logic [31:0] g;
        logic [31:0] h;
    } work_t;

    localparam work_t IV256 = 256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
    localparam work_t IV224 = 256'hc1059ed8_367cd507_3070dd17_f70e5939_ffc00b31_68581511_64f98fa7_befa4fa4;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_FINAL = 2'd2,
        ST_OUT   = 2'd3
    } state_t;

    function automatic logic [31:0] k_const(input logic [5:0] t);
        return K[t];
    endfunction

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    // Word-wise add; carries never cross word boundaries.
    function automatic work_t add_work(input work_t x, input work_t y);
        work_t s;
        s.a = x.a + y.a;
        s.b = x.b + y.b;
        s.c = x.c + y.c;
        s.d = x.d + y.d;
        s.e = x.e + y.e;
        s.f = x.f + y.f;
        s.g = x.g + y.g;
        s.h = x.h + y.h;
        return s;
    endfunction

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one purely combinational SHA-256 round.
// Ports:
//   cur  in  work_t  working variables a..h before the round
//   k    in  32      round constant K[t]
//   w    in  32      message schedule word W[t]
//   nxt  out work_t  working variables after the round
module sha256_round
    import sha2_pkg::*;
(
    input  work_t       cur,
    input  logic [31:0] k,
    input  logic [31:0] w,
    output work_t       nxt
);

    logic [31:0] t1_s;
    logic [31:0] t2_s;

    // Round arithmetic and register shuffle
    always_comb begin
        t1_s  = cur.h + big_sigma1(cur.e) + ch(cur.e, cur.f, cur.g) + k + w;
        t2_s  = big_sigma0(cur.a) + maj(cur.a, cur.b, cur.c);
        nxt.h = cur.g;
        nxt.g = cur.f;
        nxt.f = cur.e;
        nxt.e = cur.d + t1_s;
        nxt.d = cur.c;
        nxt.c = cur.b;
        nxt.b = cur.a;
        nxt.a = t1_s + t2_s;
    end

endmodule

// File: rtl/sha256_compress.sv
// sha256_compress: SHA-256 compression engine fed by an external W[t] generator.
// One round per accepted word, then a feed-forward add into the chaining hash H.
// Optional macro SHA224_EN adds input mode_224 (SHA-224 IV, last digest word blanked).
// Ports:
//   ap_clk, ap_rst_n          clock, asynchronous active-low reset
//   blk_start, init_iv        start a block; init_iv=1 reloads the IV, 0 chains from H
//   mode_224                  (SHA224_EN only) SHA-224 mode, sampled with blk_start&init_iv
//   w_valid/w_ready/w_data    W[t] stream, t = 0..ROUNDS-1
//   digest_valid/digest_ready digest handshake; digest = H0..H7, H0 in [255:224]
//   busy                      engine not idle
//   round_idx                 index of the next word to be consumed
module sha256_compress
    import sha2_pkg::*;
#(
    parameter int ROUNDS = 64,
    parameter int WORD_W = 32
) (
    input  logic                ap_clk,
    input  logic                ap_rst_n,
    input  logic                blk_start,
    input  logic                init_iv,
`ifdef SHA224_EN
    input  logic                mode_224,
`endif
    input  logic                w_valid,
    output logic                w_ready,
    input  logic [WORD_W-1:0]   w_data,
    output logic                digest_valid,
    input  logic                digest_ready,
    output logic [8*WORD_W-1:0] digest,
    output logic                busy,
    output logic [5:0]          round_idx
);

    state_t      state_r;
    state_t      state_nxt_s;
    work_t       vars_r;
    work_t       h_r;
    work_t       round_nxt_s;
    work_t       iv_sel_s;
    logic [5:0]  round_r;
    logic        w_ready_r;
    logic        digest_valid_r;
    logic        busy_r;
    logic        start_s;
    logic        accept_s;
    logic        last_s;

    // A start is honoured in IDLE, or in OUT only together with a digest handshake
    always_comb begin
        start_s  = blk_start && ((state_r == ST_IDLE) || ((state_r == ST_OUT) && digest_ready));
        accept_s = (state_r == ST_ROUND) && w_valid;
        last_s   = accept_s && (round_r == 6'(ROUNDS - 1));
    end

    // IV selection for a block started with init_iv
    always_comb begin
`ifdef SHA224_EN
        if (mode_224) begin
            iv_sel_s = IV224;
        end else begin
            iv_sel_s = IV256;
        end
`else
        iv_sel_s = IV256;
`endif
    end

    sha256_round u_round (
        .cur (vars_r),
        .k   (k_const(round_r)),
        .w   (w_data),
        .nxt (round_nxt_s)
    );

    // FSM state register
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (start_s) begin
                    state_nxt_s = ST_ROUND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_ROUND: begin
                if (last_s) begin
                    state_nxt_s = ST_FINAL;
                end else begin
                    state_nxt_s = ST_ROUND;
                end
            end
            ST_FINAL: begin
                state_nxt_s = ST_OUT;
            end
            ST_OUT: begin
                if (!digest_ready) begin
                    state_nxt_s = ST_OUT;
                end else if (blk_start) begin
                    state_nxt_s = ST_ROUND;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Working variables, chaining hash and round counter
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            h_r     <= IV256;
            vars_r  <= IV256;
            round_r <= 6'd0;
        end else if (start_s) begin
            if (init_iv) begin
                h_r    <= iv_sel_s;
                vars_r <= iv_sel_s;
            end else begin
                vars_r <= h_r;
            end
            round_r <= 6'd0;
        end else if (accept_s) begin
            vars_r <= round_nxt_s;
            if (last_s) begin
                round_r <= 6'd0;
            end else begin
                round_r <= round_r + 6'd1;
            end
        end else if (state_r == ST_FINAL) begin
            h_r <= add_work(h_r, vars_r);
        end
    end

    // Handshake and status outputs are registered from the next state
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            w_ready_r      <= 1'b0;
            digest_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            w_ready_r      <= (state_nxt_s == ST_ROUND);
            digest_valid_r <= (state_nxt_s == ST_OUT);
            busy_r         <= (state_nxt_s != ST_IDLE);
        end
    end

    assign w_ready      = w_ready_r;
    assign digest_valid = digest_valid_r;
    assign busy         = busy_r;
    assign round_idx    = round_r;

`ifdef SHA224_EN
    logic         mode_r;
    logic [255:0] h_flat_s;

    // Mode is latched only when the IV is reloaded; chained blocks keep it
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            mode_r <= 1'b0;
        end else if (start_s && init_iv) begin
            mode_r <= mode_224;
        end
    end

    // SHA-224 presents seven words; the eighth is blanked
    always_comb begin
        h_flat_s = h_r;
        if (mode_r) begin
            digest = {h_flat_s[255:32], 32'h0000_0000};
        end else begin
            digest = h_flat_s;
        end
    end
`else
    assign digest = h_r;
`endif

endmodule
